ct_ifu_ibuf_ptr_ctrl: RTL and testbench

Pointer and occupancy controller for the IFU instruction buffer: a 32-entry circular array of half-word entries. Each cycle it converts an upstream half-word create count and a downstream retire count into per-entry one-hot create/retire strobes and their valid-clock enables, which drive every entry's valid flop. It keeps the create pointer, retire pointer and entry count, and reports full/empty/free status back to the IFU fetch pipeline and the ibuf pop logic.

---
 rtl/ct_ifu_ibuf_ptr_ctrl_pkg.sv | 9 +
 rtl/ct_ifu_ibuf_ptr_mask.sv | 23 ++
 rtl/ct_ifu_ibuf_ptr_ctrl.sv | 86 ++++++++
 tb/tb_ct_ifu_ibuf_ptr_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_ibuf_ptr_ctrl_pkg.sv
// Shared ifu ibuf constants: entry array geometry and per-cycle create/retire limits.
package ct_ifu_ibuf_ptr_ctrl_pkg;
  localparam int ENTRY_NUM  = 32;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = PTR_W + 1;
  localparam int NUM_W      = 4;
  localparam int CREATE_MAX = 8;
  localparam int RETIRE_MAX = 6;
endpackage

// File: rtl/ct_ifu_ibuf_ptr_mask.sv
// Wrapped thermometer mask: num consecutive bits starting at base, modulo ENTRY_NUM.
module ct_ifu_ibuf_ptr_mask
  import ct_ifu_ibuf_ptr_ctrl_pkg::*;
(
  input  logic [PTR_W-1:0]     base,
  input  logic [NUM_W-1:0]     num,
  output logic [ENTRY_NUM-1:0] mask
);

  logic [2*ENTRY_NUM-1:0] therm;
  logic [2*ENTRY_NUM-1:0] rot;

  // Shift in a double-width field, then fold the upper half back to wrap.
  always_comb begin
    therm = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (i < int'(num)) therm[i] = 1'b1;
    end
    rot  = therm << base;
    mask = rot[ENTRY_NUM-1:0] | rot[2*ENTRY_NUM-1:ENTRY_NUM];
  end

endmodule

// File: rtl/ct_ifu_ibuf_ptr_ctrl.sv
// IBUF pointer/occupancy controller: turns create/retire counts into per-entry strobes
// and tracks create pointer, retire pointer and entry count of the 32-entry ring.
module ct_ifu_ibuf_ptr_ctrl
  import ct_ifu_ibuf_ptr_ctrl_pkg::*;
(
  input  logic                 ibuf_entry_vld_clk,
  input  logic                 cpurst_b,
  input  logic                 ibuf_flush,
  input  logic                 create_vld,
  input  logic [3:0]           create_num,
  input  logic                 retire_vld,
  input  logic [2:0]           retire_num,
  output logic                 create_grant,
  output logic [ENTRY_NUM-1:0] entry_create_vec,
  output logic [ENTRY_NUM-1:0] entry_retire_vec,
  output logic [ENTRY_NUM-1:0] entry_vld_create_clk_en_vec,
  output logic [ENTRY_NUM-1:0] entry_vld_retire_clk_en_vec,
  output logic [PTR_W-1:0]     create_ptr,
  output logic [PTR_W-1:0]     retire_ptr,
  output logic [CNT_W-1:0]     entry_cnt,
  output logic                 ibuf_full,
  output logic                 ibuf_empty,
  output logic                 ptr_clk_en
);

  localparam logic [CNT_W-1:0] ENTRY_NUM_C  = CNT_W'(ENTRY_NUM);
  localparam logic [CNT_W-1:0] CREATE_MAX_C = CNT_W'(CREATE_MAX);

  logic [CNT_W-1:0] free_cnt;
  logic             retire_req;
  logic [NUM_W-1:0] create_cnt_eff;
  logic [NUM_W-1:0] retire_cnt_eff;

  // Handshake: create_vld/create_grant is a same-cycle accept. A create seen without
  // create_grant changes nothing and upstream holds and replays it. Retire has no
  // backpressure; it is clamped to the current count. Flush overrides both.
  always_comb begin
    free_cnt     = ENTRY_NUM_C - entry_cnt;
    create_grant = cpurst_b & create_vld & ~ibuf_flush
                   & (CNT_W'(create_num) <= free_cnt);
    retire_req   = retire_vld & ~ibuf_flush;
    create_cnt_eff = create_grant ? create_num : '0;
    retire_cnt_eff = '0;
    if (retire_req) begin
      if (CNT_W'(retire_num) > entry_cnt) retire_cnt_eff = NUM_W'(entry_cnt);
      else                                retire_cnt_eff = NUM_W'(retire_num);
    end
  end

  ct_ifu_ibuf_ptr_mask u_create_mask (
    .base (create_ptr),
    .num  (create_cnt_eff),
    .mask (entry_create_vec)
  );

  ct_ifu_ibuf_ptr_mask u_retire_mask (
    .base (retire_ptr),
    .num  (retire_cnt_eff),
    .mask (entry_retire_vec)
  );

  // Created entries are always free, so the two strobe sets never overlap.
  assign entry_vld_create_clk_en_vec = entry_create_vec;
  assign entry_vld_retire_clk_en_vec = entry_retire_vec;
  assign ptr_clk_en = create_vld | retire_vld | ibuf_flush;

  always_ff @(posedge ibuf_entry_vld_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      create_ptr <= '0;
      retire_ptr <= '0;
      entry_cnt  <= '0;
    end else if (ibuf_flush) begin
      create_ptr <= '0;
      retire_ptr <= '0;
      entry_cnt  <= '0;
    end else begin
      create_ptr <= create_ptr + PTR_W'(create_cnt_eff);
      retire_ptr <= retire_ptr + PTR_W'(retire_cnt_eff);
      entry_cnt  <= entry_cnt + CNT_W'(create_cnt_eff) - CNT_W'(retire_cnt_eff);
    end
  end

  assign ibuf_full  = (ENTRY_NUM_C - entry_cnt) < CREATE_MAX_C;
  assign ibuf_empty = (entry_cnt == '0);

endmodule

// File: tb/tb_ct_ifu_ibuf_ptr_ctrl.sv
// Bench for ct_ifu_ibuf_ptr_ctrl: directed vector table, reset corner sequences and a
// random soak against a queue-of-entries reference model.
module tb_ct_ifu_ibuf_ptr_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ibuf_flush, create_vld, retire_vld;
  logic [3:0]  create_num;
  logic [2:0]  retire_num;
  logic        create_grant, ibuf_full, ibuf_empty, ptr_clk_en;
  logic [31:0] entry_create_vec, entry_retire_vec, cclk_vec, rclk_vec;
  logic [4:0]  create_ptr, retire_ptr;
  logic [5:0]  entry_cnt;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ct_ifu_ibuf_ptr_ctrl dut (
    .ibuf_entry_vld_clk          (clk),
    .cpurst_b                    (rst_b),
    .ibuf_flush                  (ibuf_flush),
    .create_vld                  (create_vld),
    .create_num                  (create_num),
    .retire_vld                  (retire_vld),
    .retire_num                  (retire_num),
    .create_grant                (create_grant),
    .entry_create_vec            (entry_create_vec),
    .entry_retire_vec            (entry_retire_vec),
    .entry_vld_create_clk_en_vec (cclk_vec),
    .entry_vld_retire_clk_en_vec (rclk_vec),
    .create_ptr                  (create_ptr),
    .retire_ptr                  (retire_ptr),
    .entry_cnt                   (entry_cnt),
    .ibuf_full                   (ibuf_full),
    .ibuf_empty                  (ibuf_empty),
    .ptr_clk_en                  (ptr_clk_en)
  );

  // Reference model: the ring contents as a queue of entry indices, oldest first.
  logic [4:0] exp_q[$];
  int         m_cptr = 0;

  logic        e_grant;
  logic [31:0] e_cvec, e_rvec;
  int          e_reff;
  logic        s_grant;
  logic [31:0] s_cvec, s_rvec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_rptr();
    return (exp_q.size() > 0) ? int'(exp_q[0]) : m_cptr;
  endfunction

  task automatic model_comb(input logic fl, input logic cv, input int cn,
                            input logic rv, input int rn);
    int free;
    free    = 32 - exp_q.size();
    e_grant = rst_b && cv && !fl && (cn <= free);
    e_cvec  = '0;
    e_rvec  = '0;
    if (e_grant) for (int i = 0; i < cn; i++) e_cvec[(m_cptr + i) % 32] = 1'b1;
    e_reff = (rv && !fl) ? ((rn < exp_q.size()) ? rn : exp_q.size()) : 0;
    for (int i = 0; i < e_reff; i++) e_rvec[exp_q[i]] = 1'b1;
  endtask

  task automatic model_commit(input logic fl, input int cn);
    if (fl) begin
      exp_q.delete();
      m_cptr = 0;
    end else begin
      for (int i = 0; i < e_reff; i++) void'(exp_q.pop_front());
      if (e_grant) begin
        for (int i = 0; i < cn; i++) exp_q.push_back(5'((m_cptr + i) % 32));
        m_cptr = (m_cptr + cn) % 32;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cptr = 0;
  endtask

  task automatic chk_state(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, "_cnt"},   32'(entry_cnt),  32'(sz));
    chk({tag, "_cptr"},  32'(create_ptr), 32'(m_cptr));
    chk({tag, "_rptr"},  32'(retire_ptr), 32'(m_rptr()));
    chk({tag, "_full"},  32'(ibuf_full),  32'((32 - sz) < 8));
    chk({tag, "_empty"}, 32'(ibuf_empty), 32'(sz == 0));
    chk({tag, "_inv"},   32'(5'(create_ptr - retire_ptr)), 32'(sz % 32));
  endtask

  // Called at posedge+1: drives one cycle, checks comb outputs mid-cycle, state after edge.
  task automatic step(input logic fl, input logic cv, input int cn,
                      input logic rv, input int rn, input string tag);
    ibuf_flush = fl;
    create_vld = cv;
    create_num = 4'(cn);
    retire_vld = rv;
    retire_num = 3'(rn);
    #4;
    model_comb(fl, cv, cn, rv, rn);
    s_grant = create_grant;
    s_cvec  = entry_create_vec;
    s_rvec  = entry_retire_vec;
    chk({tag, "_grant"}, 32'(create_grant), 32'(e_grant));
    chk({tag, "_cvec"},  entry_create_vec, e_cvec);
    chk({tag, "_rvec"},  entry_retire_vec, e_rvec);
    chk({tag, "_cclk"},  cclk_vec, e_cvec);
    chk({tag, "_rclk"},  rclk_vec, e_rvec);
    chk({tag, "_clken"}, 32'(ptr_clk_en), 32'(cv | rv | fl));
    @(posedge clk);
    #1;
    model_commit(fl, cn);
    chk_state(tag);
  endtask

  typedef struct {
    logic        fl;
    logic        cv;
    int          cn;
    logic        rv;
    int          rn;
    logic        g;
    logic [31:0] cvec;
    logic [31:0] rvec;
    int          cnt;
    int          cptr;
    int          rptr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fl, input logic cv, input int cn, input logic rv,
                     input int rn, input logic g, input logic [31:0] cvec,
                     input logic [31:0] rvec, input int cnt, input int cptr, input int rptr);
    vec_t v;
    v = '{fl, cv, cn, rv, rn, g, cvec, rvec, cnt, cptr, rptr};
    tbl.push_back(v);
  endtask

  initial begin
    //  fl  cv cn rv rn  g   cvec          rvec          cnt cptr rptr
    add(0, 1, 8, 0, 0, 1, 32'h000000FF, 32'h00000000,  8,  8,  0);
    add(0, 1, 8, 1, 6, 1, 32'h0000FF00, 32'h0000003F, 10, 16,  6);
    add(0, 1, 8, 0, 0, 1, 32'h00FF0000, 32'h00000000, 18, 24,  6);
    add(0, 1, 8, 0, 0, 1, 32'hFF000000, 32'h00000000, 26,  0,  6);
    add(0, 1, 8, 0, 0, 0, 32'h00000000, 32'h00000000, 26,  0,  6);
    add(0, 1, 7, 1, 6, 0, 32'h00000000, 32'h00000FC0, 20,  0, 12);
    add(1, 1, 8, 1, 6, 0, 32'h00000000, 32'h00000000,  0,  0,  0);
    add(0, 0, 0, 1, 3, 0, 32'h00000000, 32'h00000000,  0,  0,  0);
    add(0, 1, 8, 0, 0, 1, 32'h000000FF, 32'h00000000,  8,  8,  0);
    add(0, 1, 8, 0, 0, 1, 32'h0000FF00, 32'h00000000, 16, 16,  0);
    add(0, 1, 8, 0, 0, 1, 32'h00FF0000, 32'h00000000, 24, 24,  0);
    add(0, 0, 0, 1, 6, 0, 32'h00000000, 32'h0000003F, 18, 24,  6);
    add(0, 0, 0, 1, 6, 0, 32'h00000000, 32'h00000FC0, 12, 24, 12);
    add(0, 0, 0, 1, 6, 0, 32'h00000000, 32'h0003F000,  6, 24, 18);
    add(0, 0, 0, 1, 6, 0, 32'h00000000, 32'h00FC0000,  0, 24, 24);
    add(0, 1, 4, 0, 0, 1, 32'h0F000000, 32'h00000000,  4, 28, 24);
    add(0, 0, 0, 1, 4, 0, 32'h00000000, 32'h0F000000,  0, 28, 28);
    add(0, 1, 8, 0, 0, 1, 32'hF000000F, 32'h00000000,  8,  4, 28);
    add(0, 1, 8, 0, 0, 1, 32'h00000FF0, 32'h00000000, 16, 12, 28);
    add(0, 1, 8, 0, 0, 1, 32'h000FF000, 32'h00000000, 24, 20, 28);
    add(0, 1, 1, 0, 0, 1, 32'h00100000, 32'h00000000, 25, 21, 28);
    add(0, 1, 8, 1, 6, 0, 32'h00000000, 32'hF0000003, 19, 21,  2);
    add(0, 1, 8, 0, 0, 1, 32'h1FE00000, 32'h00000000, 27, 29,  2);
    add(0, 0, 0, 1, 3, 0, 32'h00000000, 32'h0000001C, 24, 29,  5);
    add(0, 1, 8, 1, 6, 1, 32'hE000001F, 32'h000007E0, 26,  5, 11);
    add(0, 1, 8, 0, 0, 0, 32'h00000000, 32'h00000000, 26,  5, 11);

    ibuf_flush = 0; create_vld = 0; create_num = 0; retire_vld = 0; retire_num = 0;
    rst_b = 1'b0;
    #2;
    chk("rst_cnt",   32'(entry_cnt),  32'd0);
    chk("rst_cptr",  32'(create_ptr), 32'd0);
    chk("rst_rptr",  32'(retire_ptr), 32'd0);
    chk("rst_empty", 32'(ibuf_empty), 32'd1);
    chk("rst_full",  32'(ibuf_full),  32'd0);
    chk("rst_grant", 32'(create_grant), 32'd0);
    chk("rst_cvec",  entry_create_vec, 32'd0);
    chk("rst_rvec",  entry_retire_vec, 32'd0);
    #10;
    rst_b = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].cv, tbl[i].cn, tbl[i].rv, tbl[i].rn, $sformatf("t%0d", i));
      chk($sformatf("t%0d_tgrant", i), 32'(s_grant), 32'(tbl[i].g));
      chk($sformatf("t%0d_tcvec", i), s_cvec, tbl[i].cvec);
      chk($sformatf("t%0d_trvec", i), s_rvec, tbl[i].rvec);
      chk($sformatf("t%0d_tcnt", i), 32'(entry_cnt), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_tcptr", i), 32'(create_ptr), 32'(tbl[i].cptr));
      chk($sformatf("t%0d_trptr", i), 32'(retire_ptr), 32'(tbl[i].rptr));
    end

    // Random soak with legal retire counts.
    for (int k = 0; k < 400; k++) begin
      logic fl, cv, rv;
      int   cn, rn, sz;
      sz = exp_q.size();
      fl = ($urandom_range(0, 31) == 0);
      cv = $urandom_range(0, 3) != 0;
      cn = $urandom_range(1, 8);
      rv = (sz > 0) && ($urandom_range(0, 2) != 0);
      rn = rv ? $urandom_range(1, (sz < 6) ? sz : 6) : 0;
      step(fl, cv, cn, rv, rn, "rnd");
    end

    // Fill to 32 entries, then async reset mid-cycle with requests still active.
    step(1, 0, 0, 0, 0, "fill_flush");
    for (int k = 0; k < 4; k++) step(0, 1, 8, 0, 0, "fill");
    chk("fill_cnt32", 32'(entry_cnt), 32'd32);
    chk("fill_ptr_eq", 32'(create_ptr), 32'(retire_ptr));
    chk("fill_full", 32'(ibuf_full), 32'd1);
    create_vld = 1; create_num = 4'd8; retire_vld = 1; retire_num = 3'd6;
    #2;
    rst_b = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt",   32'(entry_cnt),  32'd0);
    chk("arst_cptr",  32'(create_ptr), 32'd0);
    chk("arst_rptr",  32'(retire_ptr), 32'd0);
    chk("arst_empty", 32'(ibuf_empty), 32'd1);
    chk("arst_full",  32'(ibuf_full),  32'd0);
    chk("arst_grant", 32'(create_grant), 32'd0);
    chk("arst_cvec",  entry_create_vec, 32'd0);
    chk("arst_rvec",  entry_retire_vec, 32'd0);
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    create_vld = 0; retire_vld = 0;
    @(posedge clk);
    #1;
    chk_state("post_rst");
    step(0, 1, 8, 1, 6, "post_rst_c8");
    chk("post_rst_cnt8", 32'(entry_cnt), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
